// File: rtl/yuv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : yuv_pkg
// Purpose  : Shared types and constants for the 4:4:4 -> 4:2:2 packer.
//            Optional clamp limits are used when YUV422_CLAMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package yuv_pkg;

  // Default sample width, matching the RGB->YUV datapath.
  localparam int BITS_DEF = 9;

  // Pixel-pairing state: EVEN waits for the first pixel, ODD holds it.
  typedef enum logic [0:0] {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  // One buffered pixel pair at the default sample width.
  typedef struct packed {
    logic [BITS_DEF-1:0] y0;
    logic [BITS_DEF-1:0] u;
    logic [BITS_DEF-1:0] y1;
    logic [BITS_DEF-1:0] v;
    logic                last;
  } pair_t;

  // Studio-swing limits applied when clamping is enabled.
  localparam int Y_MIN = 16;
  localparam int Y_MAX = 235;
  localparam int C_MIN = 16;
  localparam int C_MAX = 240;

endpackage : yuv_pkg
`default_nettype wire

// File: rtl/yuv_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module   : yuv_pair_fifo
// Purpose  : Single-clock FIFO of pixel-pair entries. Full/empty/count are
//            all taken from the registered occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
module yuv_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers (wrapping modulo DEPTH) and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : yuv_pair_fifo
`default_nettype wire

// File: rtl/yuv422_packer.sv
`default_nettype none
// ============================================================================
// Module   : yuv422_packer
// Purpose  : Pairs 4:4:4 pixels, averages chroma and emits a 4:2:2 stream of
//            {Y0,Ua} / {Y1,Va} words through a pair FIFO. Odd-length lines
//            duplicate the final pixel. Define YUV422_CLAMP_EN to clamp Y to
//            [16,235] and averaged chroma to [16,240] at push time.
// Revision : 1.0 - initial release
// ============================================================================
module yuv422_packer
  import yuv_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   in_y,
  input  logic [BITS-1:0]   in_u,
  input  logic [BITS-1:0]   in_v,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [2*BITS-1:0] out_data,
  output logic              out_csel,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int EW = 4*BITS + 1;

  // Same layout as yuv_pkg::pair_t, sized by this instance's BITS.
  typedef struct packed {
    logic [BITS-1:0] y0;
    logic [BITS-1:0] u;
    logic [BITS-1:0] y1;
    logic [BITS-1:0] v;
    logic            last;
  } entry_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] hold_y, hold_u, hold_v;
  logic            phase;
  logic            accept;
  logic            push;
  entry_t          entry_raw, entry_push, entry_head;
  logic            fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [BITS:0]   u_sum, v_sum;
  logic [BITS-1:0] ua, va;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

  // Rounded average in BITS+1 bits; the halved result always fits in BITS.
  assign u_sum = {1'b0, hold_u} + {1'b0, in_u} + (BITS+1)'(1);
  assign v_sum = {1'b0, hold_v} + {1'b0, in_v} + (BITS+1)'(1);
  assign ua    = BITS'(u_sum >> 1);
  assign va    = BITS'(v_sum >> 1);

  // Pairing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EVEN;
    else        state <= state_nxt;
  end

  // Next state and pair assembly; an odd tail duplicates its pixel.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    entry_raw = '0;
    case (state)
      EVEN: begin
        if (accept) begin
          if (in_last) begin
            push      = 1'b1;
            entry_raw = '{y0: in_y, u: in_u, y1: in_y, v: in_v, last: 1'b1};
          end else begin
            state_nxt = ODD;
          end
        end
      end
      ODD: begin
        if (accept) begin
          push      = 1'b1;
          entry_raw = '{y0: hold_y, u: ua, y1: in_y, v: va, last: in_last};
          state_nxt = EVEN;
        end
      end
      default: state_nxt = EVEN;
    endcase
  end

`ifdef YUV422_CLAMP_EN
  localparam logic [BITS-1:0] Y_LO = BITS'(Y_MIN);
  localparam logic [BITS-1:0] Y_HI = BITS'(Y_MAX);
  localparam logic [BITS-1:0] C_LO = BITS'(C_MIN);
  localparam logic [BITS-1:0] C_HI = BITS'(C_MAX);

  function automatic logic [BITS-1:0] clamp(input logic [BITS-1:0] x,
                                            input logic [BITS-1:0] lo,
                                            input logic [BITS-1:0] hi);
    if (x < lo)      return lo;
    else if (x > hi) return hi;
    else             return x;
  endfunction

  // Clamp the assembled entry on its way into the FIFO (no added latency).
  always_comb begin
    entry_push      = entry_raw;
    entry_push.y0   = clamp(entry_raw.y0, Y_LO, Y_HI);
    entry_push.y1   = clamp(entry_raw.y1, Y_LO, Y_HI);
    entry_push.u    = clamp(entry_raw.u,  C_LO, C_HI);
    entry_push.v    = clamp(entry_raw.v,  C_LO, C_HI);
  end
`else
  assign entry_push = entry_raw;
`endif

  // First pixel of a pair is held until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_y <= '0;
      hold_u <= '0;
      hold_v <= '0;
    end else if (accept && state == EVEN && !in_last) begin
      hold_y <= in_y;
      hold_u <= in_u;
      hold_v <= in_v;
    end
  end

  yuv_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (entry_push),
    .pop       (out_valid && out_ready && phase),
    .pop_data  (entry_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Serializer phase: 0 = {Y0,Ua}, 1 = {Y1,Va}; toggles on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      phase <= 1'b0;
    else if (out_valid && out_ready) phase <= ~phase;
  end

  // Head entry is registered storage, so words hold steady under backpressure.
  assign out_valid = !fifo_empty;
  assign out_csel  = phase;
  assign out_last  = phase && entry_head.last;
  assign out_data  = phase ? {entry_head.y1, entry_head.v}
                           : {entry_head.y0, entry_head.u};

endmodule : yuv422_packer
`default_nettype wire

// File: tb/tb_yuv422_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_yuv422_packer
// Purpose  : Self-checking bench for yuv422_packer: directed cases plus a
//            randomized run compared against a pair-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yuv422_packer;

  localparam int BITS  = 9;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BITS-1:0]   in_y = '0, in_u = '0, in_v = '0;
  logic              in_valid = 1'b0, in_last = 1'b0;
  logic              in_ready;
  logic [2*BITS-1:0] out_data;
  logic              out_csel, out_last, out_valid;
  logic              out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Expected and observed words, encoded as {last, csel, Y[8:0], C[8:0]}.
  int exp_q[$];
  int obs_q[$];
  bit have_pend = 1'b0;
  int py, pu, pv;

  always #5 clk = ~clk;

  yuv422_packer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_y      (in_y),
    .in_u      (in_u),
    .in_v      (in_v),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_csel  (out_csel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int enc(input int y, input int c, input bit csel, input bit last);
    return (int'(last) << 19) | (int'(csel) << 18) | (y << 9) | c;
  endfunction

  function automatic int cl_y(input int y);
`ifdef YUV422_CLAMP_EN
    return (y < 16) ? 16 : (y > 235) ? 235 : y;
`else
    return y;
`endif
  endfunction

  function automatic int cl_c(input int c);
`ifdef YUV422_CLAMP_EN
    return (c < 16) ? 16 : (c > 240) ? 240 : c;
`else
    return c;
`endif
  endfunction

  function automatic void model_pair(input int y0, input int c0, input int y1,
                                     input int c1, input bit last);
    exp_q.push_back(enc(cl_y(y0), cl_c(c0), 1'b0, 1'b0));
    exp_q.push_back(enc(cl_y(y1), cl_c(c1), 1'b1, last));
  endfunction

  // Reference model: pixels pair up; an unpaired last pixel is duplicated.
  function automatic void model_accept(input int y, input int u, input int v, input bit last);
    if (have_pend) begin
      model_pair(py, (pu + u + 1) / 2, y, (pv + v + 1) / 2, last);
      have_pend = 1'b0;
    end else if (last) begin
      model_pair(y, u, y, v, 1'b1);
    end else begin
      py = y; pu = u; pv = v;
      have_pend = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    have_pend = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endfunction

  // One clock: drive at the falling edge, then judge the handshakes that the
  // next rising edge will take.
  task automatic step(input bit iv, input int y, input int u, input int v,
                      input bit il, input bit ordy);
    int got;
    @(negedge clk);
    in_valid  = iv;
    in_y      = BITS'(y);
    in_u      = BITS'(u);
    in_v      = BITS'(v);
    in_last   = il;
    out_ready = ordy;
    #1;
    if (iv && in_ready) model_accept(y, u, v, il);
    if (out_valid && out_ready) begin
      got = enc(int'(out_data[2*BITS-1:BITS]), int'(out_data[BITS-1:0]), out_csel, out_last);
      obs_q.push_back(got);
      if (exp_q.size() == 0) check_eq("unexpected_word", got, -1);
      else                   check_eq("word", got, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int cycles;
    int first_word;

    // Reset state.
    #3;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_csel_last", int'({out_csel, out_last}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pair with chroma averaging.
    model_reset();
    step(1'b1, 100, 120, 130, 1'b0, 1'b1);
    step(1'b1, 102, 124, 135, 1'b0, 1'b1);
    idle(4);
    check_eq("t1_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check_eq("t1_w0", obs_q[0], enc(cl_y(100), cl_c(122), 1'b0, 1'b0));
      check_eq("t1_w1", obs_q[1], enc(cl_y(102), cl_c(133), 1'b1, 1'b0));
    end

    // Odd-length line: last pixel duplicated, out_last on final word only.
    model_reset();
    step(1'b1, 50, 10, 20, 1'b0, 1'b1);
    step(1'b1, 52, 12, 22, 1'b0, 1'b1);
    step(1'b1, 60, 200, 201, 1'b1, 1'b1);
    idle(6);
    check_eq("t2_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check_eq("t2_w0", obs_q[0], enc(cl_y(50), cl_c(11), 1'b0, 1'b0));
      check_eq("t2_w1", obs_q[1], enc(cl_y(52), cl_c(21), 1'b1, 1'b0));
      check_eq("t2_w2", obs_q[2], enc(cl_y(60), cl_c(200), 1'b0, 1'b0));
      check_eq("t2_w3", obs_q[3], enc(cl_y(60), cl_c(201), 1'b1, 1'b1));
    end

    // Backpressure: fill the FIFO, in_ready drops, head word stays put.
    model_reset();
    first_word = (cl_y(10) << 9) | cl_c(21);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 10 + 2*i, 20 + 2*i, 30 + 2*i, 1'b0, 1'b0);
      check_eq("t3_ready_fill", int'(in_ready), 1);
      if (out_valid) check_eq("t3_stable", int'(out_data), first_word);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 99, 99, 99, 1'b0, 1'b0);
      check_eq("t3_ready_full", int'(in_ready), 0);
      check_eq("t3_stable_full", int'(out_data), first_word);
    end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check_eq("t3_ready_ph0", int'(in_ready), 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check_eq("t3_ready_ph1", int'(in_ready), 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    check_eq("t3_ready_back", int'(in_ready), 1);
    idle(10);
    check_eq("t3_drained", exp_q.size(), 0);

    // Asynchronous reset while ODD with two entries queued.
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 40 + i, 41 + i, 42 + i, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t4_out_valid", int'(out_valid), 0);
    check_eq("t4_in_ready", int'(in_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 70, 80, 90, 1'b1, 1'b1);
    idle(4);
    check_eq("t4_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check_eq("t4_w0", obs_q[0], enc(cl_y(70), cl_c(80), 1'b0, 1'b0));
      check_eq("t4_w1", obs_q[1], enc(cl_y(70), cl_c(90), 1'b1, 1'b1));
    end

    // Range extremes: clamped when enabled, passed through otherwise.
    model_reset();
    step(1'b1, 5, 250, 0, 1'b0, 1'b1);
    step(1'b1, 240, 250, 2, 1'b0, 1'b1);
    idle(4);
    check_eq("t5_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
`ifdef YUV422_CLAMP_EN
      check_eq("t5_w0", obs_q[0], enc(16, 240, 1'b0, 1'b0));
      check_eq("t5_w1", obs_q[1], enc(235, 16, 1'b1, 1'b0));
`else
      check_eq("t5_w0", obs_q[0], enc(5, 250, 1'b0, 1'b0));
      check_eq("t5_w1", obs_q[1], enc(240, 1, 1'b1, 1'b0));
`endif
    end

    // Randomized traffic against the reference model.
    model_reset();
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      bit iv;
      bit il;
      iv = ($urandom_range(0, 3) != 0);
      il = ($urandom_range(0, 7) == 0);
      if (iv && in_ready) accepted++;
      step(iv, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
           int'($urandom_range(0, 511)), il, $urandom_range(0, 2) != 0);
      cycles++;
    end
    check_eq("rand_accepted", accepted, 1000);
    // Close any held pixel so every accepted pixel leaves the block.
    if (have_pend) step(1'b1, 1, 2, 3, 1'b1, 1'b1);
    idle(4 * DEPTH + 8);
    check_eq("rand_drained", exp_q.size(), 0);
    check_eq("rand_out_idle", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_yuv422_packer
`default_nettype wire
